// File: rtl/fft_input_framer.sv
// fft_input_framer: collects ADC samples into double-buffered frames of FFT_N
// and streams each complete frame into the FFT core as {real, imag} words
// with sync on sample 0 and eop on sample FFT_N-1.
module fft_input_framer #(
    parameter int unsigned FFT_N    = 1024,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned DATA_W   = 22
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  sample_valid,
    input  logic [SAMPLE_W-1:0]   sample_data,
    input  logic                  fft_ready,
    output logic                  fft_in_valid,
    output logic                  fft_in_sync,
    output logic                  fft_in_eop,
    output logic [2*DATA_W-1:0]   fft_in_data,
    output logic                  overrun,
    output logic [15:0]           frame_drops
);

    localparam int unsigned CNT_W  = $clog2(FFT_N);
    localparam int unsigned ADDR_W = CNT_W + 1;
    localparam int unsigned PAD_W  = DATA_W - SAMPLE_W;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FFT_N - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t state_q;
    state_t state_d;

    // Two banks of FFT_N samples, bank select is the address MSB
    logic [SAMPLE_W-1:0] mem [2*FFT_N];

    logic              wr_bank;
    logic [CNT_W-1:0]  wr_count;
    logic              pending;
    logic              pend_bank;
    logic              rd_bank;
    logic [CNT_W-1:0]  rd_count;
    logic [SAMPLE_W-1:0] rd_sample;

    logic              frame_done_c;
    logic              swap_c;
    logic              drop_c;
    logic              start_c;
    logic              rd_en_c;
    logic [ADDR_W-1:0] wr_addr_c;
    logic [ADDR_W-1:0] rd_addr_c;

    // Frame completion: hand the bank over only if the reader is free and nothing waits
    always_comb begin
        wr_addr_c    = {wr_bank, wr_count};
        rd_addr_c    = {rd_bank, rd_count};
        frame_done_c = sample_valid && (wr_count == LAST_IDX);
        swap_c       = frame_done_c && !pending && (state_q != S_STREAM);
        drop_c       = frame_done_c && !swap_c;
    end

    // Reader FSM state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Reader FSM next state and read strobes
    always_comb begin
        state_d = state_q;
        start_c = 1'b0;
        rd_en_c = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending && fft_ready) begin
                    state_d = S_STREAM;
                    start_c = 1'b1;
                end
            end
            S_STREAM: begin
                rd_en_c = 1'b1;
                if (rd_count == LAST_IDX) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Sample RAM write port (contents deliberately not reset)
    always_ff @(posedge clk) begin
        if (sample_valid) begin
            mem[wr_addr_c] <= sample_data;
        end
    end

    // Writer bookkeeping: fill index, bank ownership and pending handoff
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_bank   <= 1'b0;
            wr_count  <= '0;
            pending   <= 1'b0;
            pend_bank <= 1'b0;
        end else begin
            if (sample_valid) begin
                wr_count <= frame_done_c ? '0 : wr_count + CNT_W'(1);
            end
            if (swap_c) begin
                wr_bank   <= ~wr_bank;
                pend_bank <= wr_bank;
            end
            if (swap_c) begin
                pending <= 1'b1;
            end else if (start_c) begin
                pending <= 1'b0;
            end
        end
    end

    // Reader bank/index tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_bank  <= 1'b0;
            rd_count <= '0;
        end else if (start_c) begin
            rd_bank  <= pend_bank;
            rd_count <= '0;
        end else if (rd_en_c) begin
            rd_count <= rd_count + CNT_W'(1);
        end
    end

    // Synchronous RAM read doubling as the output register stage
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_sample    <= '0;
            fft_in_valid <= 1'b0;
            fft_in_sync  <= 1'b0;
            fft_in_eop   <= 1'b0;
        end else begin
            if (rd_en_c) begin
                rd_sample <= mem[rd_addr_c];
            end
            fft_in_valid <= rd_en_c;
            fft_in_sync  <= rd_en_c && (rd_count == '0);
            fft_in_eop   <= rd_en_c && (rd_count == LAST_IDX);
        end
    end

    // Real part is the zero-extended sample, imaginary part is zero
    assign fft_in_data = {{PAD_W{1'b0}}, rd_sample, {DATA_W{1'b0}}};

    // Overrun pulse and saturating drop counter
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overrun     <= 1'b0;
            frame_drops <= '0;
        end else begin
            overrun <= drop_c;
            if (drop_c && (frame_drops != 16'hFFFF)) begin
                frame_drops <= frame_drops + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_fft_input_framer.sv
// Directed bench for fft_input_framer at FFT_N=16.
module tb_fft_input_framer;

    localparam int unsigned FFT_N    = 16;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned DATA_W   = 22;
    localparam int unsigned WORD_W   = 2 * DATA_W;

    logic                clk;
    logic                reset_n;
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic                fft_ready;
    logic                fft_in_valid;
    logic                fft_in_sync;
    logic                fft_in_eop;
    logic [WORD_W-1:0]   fft_in_data;
    logic                overrun;
    logic [15:0]         frame_drops;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int last_wr = 0;

    logic [WORD_W-1:0] data_q [$];
    logic              sync_q [$];
    logic              eop_q  [$];
    int                cyc_q  [$];

    fft_input_framer #(
        .FFT_N    (FFT_N),
        .SAMPLE_W (SAMPLE_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .fft_ready    (fft_ready),
        .fft_in_valid (fft_in_valid),
        .fft_in_sync  (fft_in_sync),
        .fft_in_eop   (fft_in_eop),
        .fft_in_data  (fft_in_data),
        .overrun      (overrun),
        .frame_drops  (frame_drops)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture every valid output word with the edge index it appeared after
    always @(negedge clk) begin
        if (fft_in_valid === 1'b1) begin
            data_q.push_back(fft_in_data);
            sync_q.push_back(fft_in_sync);
            eop_q.push_back(fft_in_eop);
            cyc_q.push_back(cyc);
        end
    end

    function automatic logic [WORD_W-1:0] exp_word(input logic [SAMPLE_W-1:0] s);
        logic [DATA_W-1:0] re;
        re = {{(DATA_W-SAMPLE_W){1'b0}}, s};
        return {re, {DATA_W{1'b0}}};
    endfunction

    task automatic clear_q();
        data_q.delete();
        sync_q.delete();
        eop_q.delete();
        cyc_q.delete();
    endtask

    task automatic apply_reset();
        sample_valid = 1'b0;
        sample_data  = '0;
        fft_ready    = 1'b0;
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        clear_q();
    endtask

    // Called at a negedge; returns at a negedge after the write edge
    task automatic send(input logic [SAMPLE_W-1:0] s, input int gap);
        sample_valid = 1'b1;
        sample_data  = s;
        @(negedge clk);
        sample_valid = 1'b0;
        last_wr = cyc;
        repeat (gap - 1) @(negedge clk);
    endtask

    task automatic wait_words(input int n, input int limit, input string tag);
        int k;
        k = 0;
        while (data_q.size() < n && k < limit) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (data_q.size() < n) begin
            errors++;
            $display("FAIL %s timeout: got %0d words, expected %0d", tag, data_q.size(), n);
        end
    endtask

    task automatic test_reset();
        sample_valid = 1'b0;
        sample_data  = '0;
        fft_ready    = 1'b0;
        reset_n      = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        checks++;
        if ({fft_in_valid, fft_in_sync, fft_in_eop, overrun} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 0000", {fft_in_valid, fft_in_sync, fft_in_eop, overrun});
        end
        checks++;
        if (fft_in_data !== '0) begin
            errors++;
            $display("FAIL reset_data: got %h, expected 0", fft_in_data);
        end
        checks++;
        if (frame_drops !== 16'd0) begin
            errors++;
            $display("FAIL reset_drops: got %0d, expected 0", frame_drops);
        end
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (fft_in_valid !== 1'b0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL reset_idle: valid=%b words=%0d, expected 0/0", fft_in_valid, data_q.size());
        end
    endtask

    task automatic test_single_frame();
        apply_reset();
        fft_ready = 1'b1;
        for (int i = 1; i <= 16; i++) send(16'(i), 4);
        wait_words(16, 60, "single");
        if (data_q.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (data_q[i] !== exp_word(16'(i + 1)) || sync_q[i] !== (i == 0) ||
                    eop_q[i] !== (i == 15) || cyc_q[i] != cyc_q[0] + i) begin
                    errors++;
                    $display("FAIL single_word%0d: got data=%h sync=%b eop=%b cyc=%0d, expected data=%h sync=%b eop=%b cyc=%0d",
                             i, data_q[i], sync_q[i], eop_q[i], cyc_q[i], exp_word(16'(i + 1)),
                             (i == 0), (i == 15), cyc_q[0] + i);
                end
            end
            checks++;
            if (cyc_q[0] - last_wr != 2) begin
                errors++;
                $display("FAIL single_sync_latency: got %0d, expected 2", cyc_q[0] - last_wr);
            end
            checks++;
            if (cyc_q[15] - last_wr != FFT_N + 1) begin
                errors++;
                $display("FAIL single_eop_latency: got %0d, expected %0d", cyc_q[15] - last_wr, FFT_N + 1);
            end
        end
        repeat (20) @(negedge clk);
        checks++;
        if (data_q.size() != 16 || frame_drops !== 16'd0) begin
            errors++;
            $display("FAIL single_once: words=%0d drops=%0d, expected 16/0", data_q.size(), frame_drops);
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        fft_ready = 1'b1;
        for (int i = 1; i <= 64; i++) begin
            send(16'(i), 1);
            if (i == 16) begin
                checks++;
                if (overrun !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_swap_overrun: got %b, expected 0", overrun);
                end
            end
            if (i == 32) begin
                checks++;
                if (overrun !== 1'b1 || frame_drops !== 16'd1) begin
                    errors++;
                    $display("FAIL b2b_overrun: got overrun=%b drops=%0d, expected 1/1", overrun, frame_drops);
                end
            end
        end
        wait_words(32, 80, "b2b");
        repeat (25) @(negedge clk);
        checks++;
        if (data_q.size() != 32 || frame_drops !== 16'd2) begin
            errors++;
            $display("FAIL b2b_totals: words=%0d drops=%0d, expected 32/2", data_q.size(), frame_drops);
        end
        if (data_q.size() >= 32) begin
            for (int i = 0; i < 32; i++) begin
                checks++;
                if (data_q[i] !== exp_word(16'(i < 16 ? i + 1 : i + 17)) ||
                    sync_q[i] !== (i % 16 == 0) || eop_q[i] !== (i % 16 == 15)) begin
                    errors++;
                    $display("FAIL b2b_word%0d: got data=%h sync=%b eop=%b, expected data=%h",
                             i, data_q[i], sync_q[i], eop_q[i], exp_word(16'(i < 16 ? i + 1 : i + 17)));
                end
            end
        end
    endtask

    task automatic test_held();
        int t_r;
        apply_reset();
        fft_ready = 1'b0;
        for (int i = 1; i <= 32; i++) send(16'(i), 4);
        repeat (5) @(negedge clk);
        checks++;
        if (frame_drops !== 16'd1 || data_q.size() != 0) begin
            errors++;
            $display("FAIL held_state: drops=%0d words=%0d, expected 1/0", frame_drops, data_q.size());
        end
        fft_ready = 1'b1;
        t_r = cyc;
        wait_words(16, 40, "held");
        if (data_q.size() >= 16) begin
            checks++;
            if (cyc_q[0] - t_r != 2) begin
                errors++;
                $display("FAIL held_start_latency: got %0d, expected 2", cyc_q[0] - t_r);
            end
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (data_q[i] !== exp_word(16'(i + 1)) || sync_q[i] !== (i == 0)) begin
                    errors++;
                    $display("FAIL held_word%0d: got %h sync=%b, expected %h", i, data_q[i], sync_q[i], exp_word(16'(i + 1)));
                end
            end
        end
    endtask

    task automatic test_max_sample();
        logic [WORD_W-1:0] expw;
        expw = {22'h00FFFF, 22'h0};
        apply_reset();
        fft_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(16'hFFFF, 1);
        wait_words(16, 40, "max");
        if (data_q.size() >= 16) begin
            checks++;
            if (data_q[0] !== expw || data_q[15] !== expw) begin
                errors++;
                $display("FAIL max_sample: got %h/%h, expected %h", data_q[0], data_q[15], expw);
            end
        end
    endtask

    task automatic test_reset_mid_stream();
        int k;
        logic [WORD_W-1:0] cur;
        apply_reset();
        fft_ready = 1'b1;
        for (int i = 0; i < 16; i++) send(16'(200 + i), 1);
        k = 0;
        cur = fft_in_data;
        while (!(fft_in_valid === 1'b1 && cur === exp_word(16'd207)) && k < 40) begin
            @(negedge clk);
            cur = fft_in_data;
            k++;
        end
        checks++;
        if (k >= 40) begin
            errors++;
            $display("FAIL midrst_reach_idx7: timeout after %0d cycles, expected word %h", k, exp_word(16'd207));
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({fft_in_valid, fft_in_sync, fft_in_eop, overrun} !== 4'b0000 || fft_in_data !== '0) begin
            errors++;
            $display("FAIL midrst_outputs: got flags=%b data=%h, expected 0",
                     {fft_in_valid, fft_in_sync, fft_in_eop, overrun}, fft_in_data);
        end
        @(negedge clk);
        reset_n = 1'b1;
        clear_q();
        repeat (20) @(negedge clk);
        checks++;
        if (data_q.size() != 0) begin
            errors++;
            $display("FAIL midrst_no_resume: got %0d words, expected 0", data_q.size());
        end
        for (int i = 0; i < 16; i++) send(16'(100 + i), 1);
        wait_words(16, 40, "midrst");
        if (data_q.size() >= 16) begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (data_q[i] !== exp_word(16'(100 + i)) || sync_q[i] !== (i == 0) || eop_q[i] !== (i == 15)) begin
                    errors++;
                    $display("FAIL midrst_word%0d: got %h sync=%b eop=%b, expected %h",
                             i, data_q[i], sync_q[i], eop_q[i], exp_word(16'(100 + i)));
                end
            end
        end
    endtask

    task automatic test_saturation();
        apply_reset();
        fft_ready = 1'b0;
        for (int i = 0; i < 16; i++) send(16'(i), 1);
        force dut.frame_drops = 16'hFFFD;
        #1;
        release dut.frame_drops;
        for (int i = 0; i < 16; i++) send(16'(i), 1);
        checks++;
        if (overrun !== 1'b1 || frame_drops !== 16'hFFFE) begin
            errors++;
            $display("FAIL sat_step: got overrun=%b drops=%h, expected 1/FFFE", overrun, frame_drops);
        end
        for (int i = 0; i < 16; i++) send(16'(i), 1);
        checks++;
        if (frame_drops !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_reach: got %h, expected FFFF", frame_drops);
        end
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < 16; i++) send(16'(i), 1);
        end
        checks++;
        if (overrun !== 1'b1 || frame_drops !== 16'hFFFF) begin
            errors++;
            $display("FAIL sat_hold: got overrun=%b drops=%h, expected 1/FFFF", overrun, frame_drops);
        end
        @(negedge clk);
        checks++;
        if (overrun !== 1'b0 || data_q.size() != 0) begin
            errors++;
            $display("FAIL sat_pulse_end: got overrun=%b words=%0d, expected 0/0", overrun, data_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_held();
        test_max_sample();
        test_reset_mid_stream();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
